// File: rtl/divrem_arb_pkg.sv
// Shared definitions for the divrem arbiter.
//  - arb_state_e : arbiter FSM encoding
//  - DefaultWidth: default operand/result width (matches divrem)
//  - rr_next()   : next round-robin pointer after a given owner
package divrem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StArm,
    StWait,
    StDone
  } arb_state_e;

  localparam int unsigned DefaultWidth = 16;

  // Owner moves to lowest priority: search restarts just after it.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable by any shared unit.
// Ports:
//  req_i   : request vector
//  ptr_i   : index of the highest-priority requester
//  gnt_o   : one-hot grant (all zero when no request)
//  idx_o   : index of the granted requester
//  valid_o : at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    logic [PtrW:0] cand;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // Lowest index at or after ptr_i wins, wrapping modulo NREQ.
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_i} + (PtrW + 1)'(off);
      if (cand >= (PtrW + 1)'(NREQ)) begin
        cand = cand - (PtrW + 1)'(NREQ);
      end
      if (!found && req_i[cand[PtrW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[cand[PtrW-1:0]] = 1'b1;
        idx_o                  = cand[PtrW-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/divrem_arbiter.sv
// Shares one divrem unit among NREQ requesters with round-robin grant.
// Operands are latched at grant; the result is registered and returned with a
// one-cycle done pulse to the owner.
// Optional feature: define DIVREM_ARB_TIMEOUT_EN to add a watchdog that ends a
// stuck operation after TIMEOUT cycles (counted from ARM) with error=1.
// Ports:
//  clk_i, rst_ni            : clock, async active-low reset
//  req_i/req_num_i/req_den_i: level requests and packed operands
//  done_o                   : one-hot completion pulse
//  quot_o/rem_o/error_o     : registered result, held until the next done
//  busy_o                   : grant through done cycle inclusive
//  dr_*                     : handshake and data to/from the divrem unit
module divrem_arbiter
  import divrem_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] req_num_i,
  input  logic [NREQ*WIDTH-1:0] req_den_i,
  output logic [NREQ-1:0]       done_o,
  output logic [WIDTH-1:0]      quot_o,
  output logic [WIDTH-1:0]      rem_o,
  output logic                  error_o,
  output logic                  busy_o,
  output logic                  dr_go_o,
  output logic [WIDTH-1:0]      dr_num_o,
  output logic [WIDTH-1:0]      dr_den_o,
  input  logic                  dr_ready_i,
  input  logic                  dr_error_i,
  input  logic [WIDTH-1:0]      dr_quot_i,
  input  logic [WIDTH-1:0]      dr_rem_i
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   owner_oh_q, owner_oh_d;
  logic [WIDTH-1:0]  num_q, num_d, den_q, den_d;
  logic [WIDTH-1:0]  quot_q, quot_d, rem_q, rem_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   gnt;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_valid;

`ifdef DIVREM_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    num_d      = num_q;
    den_d      = den_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    err_d      = err_q;
`ifdef DIVREM_ARB_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_valid && dr_ready_i) begin
          owner_d    = gnt_idx;
          owner_oh_d = gnt;
          num_d      = req_num_i[gnt_idx*WIDTH +: WIDTH];
          den_d      = req_den_i[gnt_idx*WIDTH +: WIDTH];
          state_d    = StGrant;
`ifdef DIVREM_ARB_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end
      StGrant: state_d = StArm;
      // Dead cycle: divrem may not have dropped ready yet.
      StArm: begin
        state_d = StWait;
`ifdef DIVREM_ARB_TIMEOUT_EN
        wd_d    = wd_q + 1'b1;
`endif
      end
      StWait: begin
`ifdef DIVREM_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (dr_ready_i) begin
          quot_d  = dr_quot_i;
          rem_d   = dr_rem_i;
          err_d   = dr_error_i;
          state_d = StDone;
`ifdef DIVREM_ARB_TIMEOUT_EN
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
`endif
        end
      end
      StDone: begin
        ptr_d   = PtrW'(rr_next(32'(owner_q), NREQ));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      owner_oh_q <= '0;
      num_q      <= '0;
      den_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
`ifdef DIVREM_ARB_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      num_q      <= num_d;
      den_q      <= den_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
`ifdef DIVREM_ARB_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign done_o   = (state_q == StDone) ? owner_oh_q : '0;
  assign busy_o   = (state_q != StIdle);
  assign dr_go_o  = (state_q == StGrant);
  assign dr_num_o = num_q;
  assign dr_den_o = den_q;
  assign quot_o   = quot_q;
  assign rem_o    = rem_q;
  assign error_o  = err_q;

endmodule
